// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default baud divisor.
// Defining UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_CLEANUP
  } tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 transmitter; line goes low one cycle after the request edge, Done pulses as the frame ends.
// Requests outside IDLE are dropped. UART_TX_PARITY_EN inserts an even-parity bit before stop.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic [7:0]    tx_data, data_nxt;
  logic          serial_nxt, active_nxt, done_nxt;
  logic          cnt_end;

  assign cnt_end = (cnt == CNT_LAST);

  // Outputs are registered from the current state, so the line trails the FSM by
  // one cycle; this gives the one-cycle request latency and a one-cycle Done pulse.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = bit_idx;
    data_nxt   = tx_data;
    serial_nxt = 1'b1;
    active_nxt = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (i_Tx_DV) begin
          data_nxt  = i_Tx_Byte;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        serial_nxt = 1'b0;
        active_nxt = 1'b1;
        cnt_nxt    = cnt_end ? '0 : cnt + 1'b1;
        if (cnt_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        serial_nxt = tx_data[bit_idx];
        active_nxt = 1'b1;
        cnt_nxt    = cnt_end ? '0 : cnt + 1'b1;
        if (cnt_end) begin
          idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        serial_nxt = ^tx_data;
        active_nxt = 1'b1;
        cnt_nxt    = cnt_end ? '0 : cnt + 1'b1;
        if (cnt_end) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        active_nxt = 1'b1;
        cnt_nxt    = cnt_end ? '0 : cnt + 1'b1;
        if (cnt_end) state_nxt = ST_CLEANUP;
      end
      ST_CLEANUP: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      tx_data     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= idx_nxt;
      tx_data     <= data_nxt;
      o_Tx_Serial <= serial_nxt;
      o_Tx_Active <= active_nxt;
      o_Tx_Done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core (CLKS_PER_BIT=4 plus a default-divisor instance).
// Honours UART_TX_PARITY_EN for the frame length and parity bit.
module tb_uart_tx_core;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       abort;
    int         dv_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_serial, tx_done;
  logic       dv2;
  logic [7:0] byte2;
  logic       act2, ser2, done2;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  exp_t sb_q[$];

  uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Active(tx_active), .o_Tx_Serial(tx_serial), .o_Tx_Done(tx_done)
  );

  uart_tx_core dut_def (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Active(act2), .o_Tx_Serial(ser2), .o_Tx_Done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge tx_done) n_done++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called between clock edges; the request is sampled on the next rising edge.
  task automatic send(input logic [7:0] d, input logic par, input logic ab);
    exp_t e;
    e.d = d;
    e.par = par;
    e.abort = ab;
    e.dv_edge = cyc + 1;
    sb_q.push_back(e);
    tx_byte = d;
    tx_dv = 1'b1;
    @(posedge clk);
    #1 tx_dv = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (tx_done === 1'b1) break;
    end
    check("done_seen", tx_done, 1);
  endtask

  // Monitor: every frame on the line is checked cycle by cycle against the queue head.
  initial begin : monitor
    exp_t        e;
    logic [10:0] fr, got;
    int          glitch;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_active === 1'b1) begin
        check("frame_expected", sb_q.size() > 0, 1);
        if (sb_q.size() == 0) begin
          while (tx_active === 1'b1 && rst_n === 1'b1) @(negedge clk);
        end else begin
          e = sb_q.pop_front();
`ifdef UART_TX_PARITY_EN
          fr = {1'b1, e.par, e.d, 1'b0};
`else
          fr = {1'b0, 1'b1, e.d, 1'b0};
`endif
          check("start_edge", cyc, e.dv_edge + 1);
          got = '0;
          glitch = 0;
          aborted = 1'b0;
          for (int t = 0; t < FB * CPB; t++) begin
            if (t > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (t % CPB == CPB / 2) got[t / CPB] = tx_serial;
            if (tx_serial !== fr[t / CPB] || tx_active !== 1'b1) glitch++;
          end
          check("aborted", aborted, e.abort);
          if (!aborted) begin
            check("frame_bits", got, fr);
            check("bit_hold", glitch, 0);
            @(negedge clk);
            check("done_rise_active_fall", {tx_done, tx_active}, 2'b10);
            @(negedge clk);
            check("done_fall", tx_done, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0, n2, w, k;
    rst_n = 1'b0;
    tx_dv = 1'b0;
    tx_byte = 8'h00;
    dv2 = 1'b0;
    byte2 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_serial", tx_serial, 1);
    check("reset_active", tx_active, 0);
    check("reset_done", tx_done, 0);

    // First request on the first edge after reset release; 0x55 alternates the line.
    #2 rst_n = 1'b1;
    send(8'h55, 1'b0, 1'b0);
    wait_done(60);
    repeat (4) @(negedge clk);

    // Byte and a second request change mid-frame; neither may touch the frame.
    send(8'h80, 1'b1, 1'b0);
    tx_byte = 8'hFF;
    repeat (12) @(negedge clk);
    tx_dv = 1'b1;
    @(posedge clk);
    #1 tx_dv = 1'b0;
    wait_done(60);
    repeat (6) @(negedge clk);
    check("no_extra_frame", tx_active, 0);

    // Back-to-back: request during the Done cycle (first IDLE cycle).
    send(8'hA5, 1'b0, 1'b0);
    wait_done(60);
    send(8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    check("gap_idle_high", tx_serial, 1);
    @(negedge clk);
    check("gap_then_start", tx_serial, 0);
    wait_done(60);
    repeat (3) @(negedge clk);

    // Abort 0xF0 in the middle of data bit 3.
    send(8'hF0, 1'b0, 1'b1);
    t0 = cyc;
    while (cyc < t0 + 1 + 4 * CPB + 1) @(negedge clk);
    #1 check("pre_abort_line", tx_serial, 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_serial", tx_serial, 1);
    check("abort_active", tx_active, 0);
    check("abort_done", tx_done, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    send(8'h0F, 1'b0, 1'b0);
    wait_done(60);
    repeat (3) @(negedge clk);

    // Parity cases: 0x07 has odd weight, 0x03 even.
    send(8'h07, 1'b1, 1'b0);
    wait_done(60);
    repeat (3) @(negedge clk);
    send(8'h03, 1'b0, 1'b0);
    wait_done(60);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("done_pulses", n_done, 7);

    // Default divisor: 434-cycle bits.
    @(negedge clk);
    byte2 = 8'h41;
    dv2 = 1'b1;
    n2 = cyc + 1;
    @(posedge clk);
    #1 dv2 = 1'b0;
    for (k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ser2 === 1'b0) break;
    end
    check("def_start_edge", cyc, n2 + 1);
    w = 0;
    while (ser2 === 1'b0 && w < 1000) begin
      w++;
      @(negedge clk);
    end
    check("def_start_width", w, 434);
    for (k = 0; k < 5000; k++) begin
      if (done2 === 1'b1) break;
      @(negedge clk);
    end
    check("def_done_seen", done2, 1);
    check("def_frame_len", cyc - (n2 + 1), FB * 434);
    @(negedge clk);
    check("def_done_fall", {done2, act2}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per serial bit (434 = 50 MHz / 115200 baud); legal range 2..65535.
REQ-002 i_Clock  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 i_Rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i_Tx_DV  input  1  SHALL be the single-cycle start request, qualifying i_Tx_Byte.
REQ-005 i_Tx_Byte  input  8  SHALL be the byte to transmit.
REQ-006 o_Tx_Active  output  1  SHALL be high while a frame is being transmitted.
REQ-007 o_Tx_Serial  output  1  SHALL be the serial line, idle high.
REQ-008 o_Tx_Done  output  1  SHALL pulse high for exactly one cycle when a frame completes.

Function
REQ-009 Frame SHALL be 8N1: start bit 0, data bits 0..7 LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-010 States SHALL be IDLE, START, DATA, STOP, CLEANUP; IDLE->START on i_Tx_DV; START->DATA, DATA->DATA (bit index 0..7), DATA->STOP after bit 7, STOP->CLEANUP after CLKS_PER_BIT cycles each; CLEANUP->IDLE after one cycle.
REQ-011 i_Tx_Byte SHALL be latched into an internal register on the edge where i_Tx_DV is sampled high in IDLE; later input changes SHALL NOT affect the frame.
REQ-012 Latency: if i_Tx_DV is sampled high at edge N, o_Tx_Serial SHALL be 0 and o_Tx_Active 1 from edge N+1.
REQ-013 o_Tx_Active SHALL fall and o_Tx_Done SHALL rise at edge N+1+10*CLKS_PER_BIT; o_Tx_Done SHALL fall on the following edge.
REQ-014 i_Tx_DV asserted in any state other than IDLE SHALL be ignored (no queuing, no frame corruption).
REQ-015 i_Tx_DV sampled in the CLEANUP cycle SHALL be ignored; a request in the first IDLE cycle after CLEANUP SHALL start a new frame (back-to-back gap of one idle cycle minimum).
REQ-016 o_Tx_Serial SHALL be 1 in IDLE, STOP and CLEANUP.
REQ-017 Bit counter SHALL count 0..CLKS_PER_BIT-1 and clear on every bit transition; width SHALL be $clog2(CLKS_PER_BIT).

Reset
REQ-018 While i_Rst_n is low: state IDLE, o_Tx_Serial 1, o_Tx_Active 0, o_Tx_Done 0, counters and data register 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); no o_Tx_Done pulse SHALL be produced for the aborted frame.
REQ-020 First request SHALL be accepted on the first rising edge after i_Rst_n deasserts.

Configuration
REQ-021 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be sent between data bit 7 and the stop bit via an added PARITY state; frame length becomes 11*CLKS_PER_BIT and REQ-013 uses 11.
REQ-022 Macro undefined: no parity state or logic SHALL exist; frame is 8N1 exactly.

Structure
REQ-023 A shared package uart_pkg SHALL hold the state-encoding typedef and the default CLKS_PER_BIT constant (434).
REQ-024 Block SHALL be a single module with no sub-modules; the baud counter is inline.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-025 Send 0x55 -> o_Tx_Serial 0,1,0,1,0,1,0,1,0,1 each held 4 cycles; o_Tx_Done one pulse 41 cycles after the DV edge.
REQ-026 Send 0x80, then change i_Tx_Byte to 0xFF and pulse i_Tx_DV mid-frame -> line carries 0,0,0,0,0,0,0,0,1,1 only; one o_Tx_Done pulse.
REQ-027 Back-to-back 0xA5 then 0x3C issued in the first IDLE cycle after Done -> both frames correct, exactly one idle-high cycle between stop and next start.
REQ-028 Assert i_Rst_n low during data bit 3 of 0xF0 -> o_Tx_Serial 1 and o_Tx_Active 0 immediately, no o_Tx_Done pulse; next 0x0F frame correct.
REQ-029 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 before stop; send 0x03 -> parity bit 0; Done at 45 cycles.
REQ-030 Default CLKS_PER_BIT=434, send 0x41 -> start bit width 434 cycles, total frame 4340 cycles.
